// File: rtl/load_store_unit.sv
// Request-side controller for the S-Machine data memory: computes effective
// addresses, sequences single-cycle stores and registered-read loads.
module load_store_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              ea_wrapped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              mem_read_write_q, mem_read_write_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              ea_wrapped_q, ea_wrapped_d;

  logic [ADDR_W:0]   ea_sum;
  logic [ADDR_W-1:0] ea;
  logic              ea_wrap;
  logic              accept;

  assign ea_sum = {1'b0, req_base} + {1'b0, req_offset};
  assign ea     = ea_sum[ADDR_W-1:0];
  // A negative offset underflows exactly when the unsigned add produces no carry.
  assign ea_wrap = req_offset[ADDR_W-1] ? ~ea_sum[ADDR_W] : ea_sum[ADDR_W];

  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d          = state_q;
    mem_addr_d       = mem_addr_q;
    mem_data_in_d    = mem_data_in_q;
    mem_read_write_d = mem_read_write_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_data_d       = rsp_data_q;
    rsp_addr_d       = rsp_addr_q;
    ea_wrapped_d     = ea_wrapped_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mem_addr_d   = ea;
          ea_wrapped_d = ea_wrapped_q | ea_wrap;
          if (req_write) begin
            mem_data_in_d    = req_wdata;
            mem_read_write_d = 1'b1;
            state_d          = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        mem_read_write_d = 1'b0;
        state_d          = S_IDLE;
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_data_d  = mem_data_out;
        rsp_addr_d  = mem_addr_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        mem_read_write_d = 1'b0;
        rsp_valid_d      = 1'b0;
        state_d          = S_IDLE;
      end
    endcase
  end

  // Async reset drops the write strobe at once, so an aborted store never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      mem_addr_q       <= '0;
      mem_data_in_q    <= '0;
      mem_read_write_q <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_addr_q       <= '0;
      ea_wrapped_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      mem_addr_q       <= mem_addr_d;
      mem_data_in_q    <= mem_data_in_d;
      mem_read_write_q <= mem_read_write_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_addr_q       <= rsp_addr_d;
      ea_wrapped_q     <= ea_wrapped_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_data_in    = mem_data_in_q;
  assign mem_read_write = mem_read_write_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_addr       = rsp_addr_q;
  assign ea_wrapped     = ea_wrapped_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Request-side controller directly upstream of the S-Machine data memory. It accepts load/store requests from the execute stage over a valid/ready handshake and computes the effective address. It drives the memory's `read_write`, `addr` and `data_in` pins, and captures the memory's registered `data_out` one cycle after the read is issued. Load data returns to the execute stage over a valid/ready response channel; stores complete silently.

## Interface
- `ADDR_W`, default 8: memory address width; matches the 256-word data memory.
- `DATA_W`, default 16: data word width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_base` in ADDR_W: base address, unsigned.
- `req_offset` in ADDR_W: offset, two's complement.
- `req_wdata` in DATA_W: store data.
- `rsp_valid` out 1: load data available.
- `rsp_ready` in 1: execute stage takes the response.
- `rsp_data` out DATA_W: loaded word.
- `rsp_addr` out ADDR_W: effective address of the returned load.
- `mem_read_write` out 1: to memory `read_write`; 1 = write.
- `mem_addr` out ADDR_W: to memory `addr`.
- `mem_data_in` out DATA_W: to memory `data_in`.
- `mem_data_out` in DATA_W: from memory `data_out`; registered, valid the cycle after a read edge.
- `ea_wrapped` out 1: sticky flag set when any effective-address computation overflowed or underflowed; cleared only by reset.

## Operation
- Effective address: EA = (req_base + req_offset) mod 2^ADDR_W.
  - `req_offset` is sign-extended before the add.
  - Wrap in either direction sets `ea_wrapped`.
  - Example: 0xFE + 0x03 gives 0x01; 0x01 + 0xFE (that is, -2) gives 0xFF.
- States and transitions:
  - IDLE: `req_ready` = 1. On accept (req_valid && req_ready), latch `mem_addr` <= EA.
    - If `req_write` = 1: latch `mem_data_in` <= `req_wdata`, set `mem_read_write` <= 1, go to WRITE.
    - If `req_write` = 0: keep `mem_read_write` = 0, go to READ.
  - WRITE: memory writes at this cycle's edge. Then `mem_read_write` <= 0; go to IDLE.
  - READ: memory samples `mem_addr` at this edge. Go to CAPTURE.
  - CAPTURE: `mem_data_out` is valid. Latch `rsp_data` <= `mem_data_out`, `rsp_addr` <= `mem_addr`, `rsp_valid` <= 1; go to RESP.
  - RESP: hold `rsp_valid`, `rsp_data` and `rsp_addr` stable until rsp_ready = 1 at an edge. Then `rsp_valid` <= 0; go to IDLE.
- `req_ready` = (state == IDLE) && rst_n.
  - No request is accepted in WRITE, READ, CAPTURE or RESP.
- `mem_read_write` is 1 only during WRITE.
  - The memory performs a read in every other cycle. That read is harmless because its `data_out` is ignored outside CAPTURE.
- `mem_addr` and `mem_data_in` hold their last values when idle.

## Timing
- Reset (rst_n low, asynchronous), regardless of current state:
  - state = IDLE.
  - `mem_read_write` = 0, so no spurious write ever occurs.
  - `mem_addr` = 0, `mem_data_in` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_addr` = 0.
  - `ea_wrapped` = 0.
  - `req_ready` = 0.
- Reset mid-operation:
  - A pending load is discarded and no response is produced.
  - A store aborted in WRITE before its write edge does not reach memory.
- Store: accepted at edge E0, memory written at E1, `req_ready` high again after E1. Throughput is one store per 2 cycles.
- Load: accepted at E0, memory reads at E1, captured at E2, `rsp_valid` high after E2. Accept-to-response latency is 2 cycles.
  - If rsp_ready is already high during the first RESP cycle, `rsp_valid` drops at E3 and the next request is accepted at E4 at the earliest.
  - Minimum load throughput is one per 4 cycles.
- Backpressure: `rsp_valid` stays high and `rsp_data` stays stable for every cycle that `rsp_ready` = 0.
- Request inputs are sampled only on the accept edge. Changes at any other time are ignored.

## Test plan
- Reset, then store 0xBEEF at base 0x10, offset 0x05 -> `mem_read_write` = 1 for exactly one cycle with `mem_addr` = 0x15; memory word 0x15 = 0xBEEF; `rsp_valid` never asserts.
- Load with base 0x10, offset 0x05, `rsp_ready` = 1 -> `rsp_valid` asserts 2 cycles after accept with `rsp_data` = 0xBEEF, `rsp_addr` = 0x15, for exactly one cycle.
- Wrap cases: store 0x1234 with base 0xFE, offset 0x03 -> written to 0x01 and `ea_wrapped` = 1. Then load with base 0x01, offset 0x00 -> `rsp_data` = 0x1234.
- Backpressure: load with `rsp_ready` = 0 for 5 cycles -> `rsp_valid` and `rsp_data` stay stable and `req_ready` = 0 throughout; `rsp_ready` = 1 -> one handshake, then `req_ready` = 1.
- Reset in READ: deassert `rst_n` one cycle after a load accept -> outputs return to reset values immediately and no `rsp_valid` after release. Reset in WRITE: assert `rst_n` low before the write edge -> memory at that address unchanged.
- Back-to-back: hold `req_valid` high with the sequence store 0x0001 at 0x20, store 0x0002 at 0x21, load 0x20, load 0x21 -> accepts spaced per the throughput rules; responses 0x0001 then 0x0002 in order.
